// File: rtl/synth_pkg.sv
// synth_pkg: FSM state encodings and elaboration helpers shared by the multi-cycle arithmetic blocks
package synth_pkg;
   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_FIX  = 2'd2,
      DIV_DONE = 2'd3
   } div_state_t;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step: shift in a dividend bit, trial subtract, keep or restore
module div_step #(
   parameter int C_WIDTH = 32,
   parameter int USE_CLA = 1
) (
   input  logic [C_WIDTH-1:0] rem_in,
   input  logic               bit_in,
   input  logic [C_WIDTH-1:0] dvs,
   output logic [C_WIDTH-1:0] rem_out,
   output logic               q_bit
);
   logic [C_WIDTH:0] shifted, trial;
   logic             no_borrow, unused_msb;
   assign shifted = {rem_in, bit_in};
   subtractor #(.W(C_WIDTH + 1), .USE_CLA(USE_CLA)) u_sub (
      .a   (shifted),
      .b   ({1'b0, dvs}),
      .sub (1'b1),
      .y   (trial),
      .cout(no_borrow)
   );
   // remainder stays below the divisor, so the top bit is always zero after selection
   assign unused_msb = trial[C_WIDTH];
   assign q_bit      = no_borrow;
   assign rem_out    = no_borrow ? trial[C_WIDTH-1:0] : shifted[C_WIDTH-1:0];
endmodule

// File: rtl/sign_converter.sv
// sign_converter: two's-complement negate when neg is set, pass-through otherwise
module sign_converter #(
   parameter int W = 32
) (
   input  logic [W-1:0] x,
   input  logic         neg,
   output logic [W-1:0] y
);
   assign y = neg ? (~x + 1'b1) : x;
endmodule

// File: rtl/subtractor.sv
// subtractor: a-b (sub=1) or a+b (sub=0) with carry out; USE_CLA picks prefix lookahead or ripple carries
module subtractor #(
   parameter int W       = 33,
   parameter int USE_CLA = 1
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] y,
   output logic         cout
);
   logic [W-1:0] bb, p, c;
   logic         co;
   assign bb = sub ? ~b : b;
   assign p  = a ^ bb;
   generate
      if (USE_CLA != 0) begin : g_cla
         logic [W-1:0] gg, pp, gn, pn;
         // Kogge-Stone prefix; carry-in folded into bit 0 generate
         always_comb begin
            gg    = a & bb;
            gg[0] = gg[0] | (p[0] & sub);
            pp    = p;
            for (int d = 1; d < W; d = d * 2) begin
               gn = gg;
               pn = pp;
               for (int i = d; i < W; i++) begin
                  gn[i] = gg[i] | (pp[i] & gg[i-d]);
                  pn[i] = pp[i] & pp[i-d];
               end
               gg = gn;
               pp = pn;
            end
            c  = {gg[W-2:0], sub};
            co = gg[W-1];
         end
      end else begin : g_ripple
         logic cr;
         always_comb begin
            c  = '0;
            cr = sub;
            for (int i = 0; i < W; i++) begin
               c[i] = cr;
               cr   = (a[i] & bb[i]) | (p[i] & cr);
            end
            co = cr;
         end
      end
   endgenerate
   assign y    = p ^ c;
   assign cout = co;
endmodule

// File: rtl/multi_cycle_divider.sv
// multi_cycle_divider: sequential restoring fixed-point divider, y = (a << FIXED_POINT) / b, one bit per cycle.
// Define DIVIDER_SATURATE_EN to clamp y on overflow / divide-by-zero instead of wrapping.
module multi_cycle_divider
   import synth_pkg::*;
#(
   parameter int C_WIDTH     = 32,
   parameter int FIXED_POINT = 8,
   parameter int USE_CLA     = 1
) (
   input  logic               ctl_clk,
   input  logic               reset,
   input  logic [C_WIDTH-1:0] a,
   input  logic [C_WIDTH-1:0] b,
   input  logic               signed_cal,
   input  logic               trigger,
   output logic               ready,
   output logic               done,
   output logic [C_WIDTH-1:0] y,
   output logic               div_by_zero,
   output logic               overflow
);
   localparam int N  = C_WIDTH + FIXED_POINT;
   localparam int CW = clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [N-1:0] LIM_U  = {{FIXED_POINT{1'b0}}, {C_WIDTH{1'b1}}};
   localparam logic [N-1:0] LIM_SP = LIM_U >> 1;
   localparam logic [N-1:0] LIM_SN = LIM_SP + N'(1);
   div_state_t         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [C_WIDTH-1:0] rem_q, rem_d, dvs_q, dvs_d, y_q, y_d;
   logic [N-1:0]       q_q, q_d, dvd_q, dvd_d;
   logic               qsign_q, qsign_d, sgn_q, sgn_d, dz_q, dz_d, dzf_q, dzf_d, ovf_q, ovf_d;
   logic [C_WIDTH-1:0] a_mag, b_mag, step_rem, q_signed, y_fix;
   logic [N-1:0]       lim;
   logic               accept, b_zero, step_q, qsign_new, ovf_fix;
   sign_converter #(.W(C_WIDTH)) u_abs_a (.x(a), .neg(signed_cal & a[C_WIDTH-1]), .y(a_mag));
   sign_converter #(.W(C_WIDTH)) u_abs_b (.x(b), .neg(signed_cal & b[C_WIDTH-1]), .y(b_mag));
   sign_converter #(.W(C_WIDTH)) u_out   (.x(q_q[C_WIDTH-1:0]), .neg(qsign_q), .y(q_signed));
   div_step #(.C_WIDTH(C_WIDTH), .USE_CLA(USE_CLA)) u_step (
      .rem_in (rem_q),
      .bit_in (dvd_q[N-1]),
      .dvs    (dvs_q),
      .rem_out(step_rem),
      .q_bit  (step_q)
   );
   assign accept  = trigger & ready;
   assign b_zero  = b == '0;
   assign lim     = sgn_q ? (qsign_q ? LIM_SN : LIM_SP) : LIM_U;
   assign ovf_fix = ~dz_q & (q_q > lim);
`ifdef DIVIDER_SATURATE_EN
   logic [C_WIDTH-1:0] sat;
   assign qsign_new = (b_zero ? a[C_WIDTH-1] : a[C_WIDTH-1] ^ b[C_WIDTH-1]) & signed_cal;
   assign sat       = sgn_q ? (qsign_q ? {1'b1, {(C_WIDTH-1){1'b0}}} : {1'b0, {(C_WIDTH-1){1'b1}}}) : '1;
   assign y_fix     = (ovf_fix | dz_q) ? sat : q_signed;
`else
   assign qsign_new = (a[C_WIDTH-1] ^ b[C_WIDTH-1]) & signed_cal;
   assign y_fix     = dz_q ? '1 : q_signed;
`endif
   always_ff @(posedge ctl_clk or posedge reset) begin
      if (reset) state_q <= DIV_IDLE;
      else       state_q <= state_d;
   end
   always_comb begin
      state_d = accept              ? (b_zero ? DIV_FIX : DIV_CALC) :
                state_q == DIV_CALC ? (cnt_q == LAST ? DIV_FIX : DIV_CALC) :
                state_q == DIV_FIX  ? DIV_DONE :
                state_q == DIV_DONE ? DIV_IDLE : state_q;
   end
   always_comb begin
      ready = state_q == DIV_IDLE || state_q == DIV_DONE;
      done  = state_q == DIV_DONE;
   end
   always_comb begin
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      q_d     = q_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      qsign_d = qsign_q;
      sgn_d   = sgn_q;
      dz_d    = dz_q;
      y_d     = y_q;
      dzf_d   = dzf_q;
      ovf_d   = ovf_q;
      if (accept) begin
         cnt_d   = '0;
         rem_d   = '0;
         q_d     = '0;
         dvd_d   = {a_mag, {FIXED_POINT{1'b0}}};
         dvs_d   = b_mag;
         qsign_d = qsign_new;
         sgn_d   = signed_cal;
         dz_d    = b_zero;
      end else if (state_q == DIV_CALC) begin
         cnt_d = cnt_q + 1'b1;
         rem_d = step_rem;
         q_d   = {q_q[N-2:0], step_q};
         dvd_d = dvd_q << 1;
      end else if (state_q == DIV_FIX) begin
         y_d   = y_fix;
         dzf_d = dz_q;
         ovf_d = ovf_fix;
      end
   end
   always_ff @(posedge ctl_clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         rem_q   <= '0;
         q_q     <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         qsign_q <= 1'b0;
         sgn_q   <= 1'b0;
         dz_q    <= 1'b0;
         y_q     <= '0;
         dzf_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         q_q     <= q_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         qsign_q <= qsign_d;
         sgn_q   <= sgn_d;
         dz_q    <= dz_d;
         y_q     <= y_d;
         dzf_q   <= dzf_d;
         ovf_q   <= ovf_d;
      end
   end
   assign y           = y_q;
   assign div_by_zero = dzf_q;
   assign overflow    = ovf_q;
endmodule
